// File: rtl/ifu_fq_pkg.sv
// Shared types and constants for the fetch unit and its queue.
package ifu_pkg;

    localparam int INSN_W = 32;
    localparam int PC_W   = 62;

    localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fq_if.sv
// IRAM read port, redirect input and decode handshake of the fetch unit.
interface ifu_fq_if
    import ifu_pkg::*;
#(
    parameter int IRAM_AW = 16
) ();

    logic                i_flush;
    logic [PC_W-1:0]     i_pc_tgt;
    logic [IRAM_AW-1:0]  o_iram_addr;
    logic                o_iram_re;
    logic [INSN_W-1:0]   i_iram_rdata;
    logic                o_valid;
    logic                i_ready;
    logic [INSN_W-1:0]   o_insn;
    logic [PC_W+1:0]     o_pc;

    modport master (
        input  i_flush, i_pc_tgt, i_iram_rdata, i_ready,
        output o_iram_addr, o_iram_re, o_valid, o_insn, o_pc
    );

    modport slave (
        output i_flush, i_pc_tgt, i_iram_rdata, i_ready,
        input  o_iram_addr, o_iram_re, o_valid, o_insn, o_pc
    );

endinterface

// File: rtl/ifu_fq_fetch_queue.sv
// Circular buffer of fetched {pc, insn} entries; DEPTH must be a power of two.
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fq_entry_t                  push_data,
    input  logic                       pop,
    input  logic                       clear,
    output fq_entry_t                  head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fq_entry_t       mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset, so an empty queue must not expose stale words.
    assign head_data = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/ifu_fq.sv
// Instruction fetch unit: credit-throttled IRAM reads feeding a decode queue.
// Optional IFU_BYPASS_EN presents a returning word to decode in the same cycle when the queue is empty.
module ifu_fq
    import ifu_pkg::*;
#(
    parameter int              IRAM_AW  = 16,
    parameter int              FQ_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    ifu_fq_if.master  bus
);

    localparam int CW = $clog2(FQ_DEPTH+1);

    logic [PC_W-1:0] fpc;
    logic [PC_W-1:0] pc_d1;
    logic            inflight;

    fq_entry_t       head_ent;
    fq_entry_t       ret_ent;
    logic [CW-1:0]   q_count;
    logic            q_nonempty;
    logic            iram_re;
    logic            byp;
    logic            q_push;
    logic            q_pop;

    assign q_nonempty = (q_count != '0);
    assign ret_ent    = '{pc: pc_d1, insn: bus.i_iram_rdata};

    // Counting the in-flight read as occupied is what keeps the queue from overflowing.
    assign iram_re = rst_n && !bus.i_flush
                     && ((32'(q_count) + 32'(inflight)) < FQ_DEPTH);

`ifdef IFU_BYPASS_EN
    assign byp = !q_nonempty && inflight && !bus.i_flush;
`else
    assign byp = 1'b0;
`endif

    assign q_pop  = q_nonempty && bus.i_ready && !bus.i_flush;
    assign q_push = inflight && !bus.i_flush && !(byp && bus.i_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc      <= RESET_PC;
            pc_d1    <= '0;
            inflight <= 1'b0;
        end else if (bus.i_flush) begin
            fpc      <= bus.i_pc_tgt;
            inflight <= 1'b0;
        end else begin
            inflight <= iram_re;
            if (iram_re) begin
                fpc   <= fpc + 1'b1;
                pc_d1 <= fpc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (ret_ent),
        .pop       (q_pop),
        .clear     (bus.i_flush),
        .head_data (head_ent),
        .count     (q_count)
    );

    always_comb begin
        bus.o_valid = q_nonempty;
        bus.o_insn  = head_ent.insn;
        bus.o_pc    = {head_ent.pc, 2'b00};
        if (byp) begin
            bus.o_valid = 1'b1;
            bus.o_insn  = ret_ent.insn;
            bus.o_pc    = {ret_ent.pc, 2'b00};
        end
    end

    assign bus.o_iram_re   = iram_re;
    assign bus.o_iram_addr = fpc[IRAM_AW-1:0];

endmodule

// File: tb/tb_ifu_fq.sv
// Bench for ifu_fq: directed vector table, corner sequences and random traffic against a queue model.
module tb_ifu_fq;

    localparam int          IRAM_AW  = 16;
    localparam int          FQ_DEPTH = 4;
    localparam logic [61:0] RST_PC   = 62'h0;

    logic clk;
    logic rst_n;
    logic [31:0] iram_dat;

    ifu_fq_if #(.IRAM_AW(IRAM_AW)) bus ();

    ifu_fq #(
        .IRAM_AW  (IRAM_AW),
        .FQ_DEPTH (FQ_DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IRAM returns the zero-extended word address one cycle after a read; junk otherwise.
    always @(posedge clk) begin
        if (bus.o_iram_re) iram_dat <= {16'h0, bus.o_iram_addr};
        else               iram_dat <= $urandom;
    end
    assign bus.i_iram_rdata = iram_dat;

    typedef struct {
        logic [61:0] pc;
        logic [31:0] insn;
    } m_ent_t;

    typedef struct {
        bit          rdy;
        bit          re;
        logic [15:0] addr;
        bit          valid;
        logic [63:0] pc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    m_ent_t      mq[$];
    logic [61:0] m_fpc;
    logic [61:0] m_pcd1;
    bit          m_infl;

    logic        obs_re;
    logic        obs_valid;
    logic [15:0] obs_addr;
    logic [63:0] obs_pc;
    logic [31:0] obs_insn;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_fpc  = RST_PC;
        m_pcd1 = '0;
        m_infl = 1'b0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit fl, input logic [61:0] tgt, input bit rdy);
        int          sz;
        bit          byp;
        bit          e_re;
        bit          e_valid;
        m_ent_t      e;
        logic [31:0] rd;
        @(negedge clk);
        bus.i_flush  = fl;
        bus.i_pc_tgt = tgt;
        bus.i_ready  = rdy;
        #1;
        obs_re    = bus.o_iram_re;
        obs_valid = bus.o_valid;
        obs_addr  = bus.o_iram_addr;
        obs_pc    = bus.o_pc;
        obs_insn  = bus.o_insn;

        sz  = mq.size();
        rd  = {16'h0, m_pcd1[15:0]};
        byp = 1'b0;
`ifdef IFU_BYPASS_EN
        byp = (sz == 0) && m_infl && !fl;
`endif
        e_re    = !fl && ((sz + int'(m_infl)) < FQ_DEPTH);
        e_valid = (sz != 0) || byp;
        if (sz != 0) e = mq[0];
        else         e = '{pc: m_pcd1, insn: rd};

        chk("re", 64'(obs_re), 64'(e_re));
        chk("addr", 64'(obs_addr), 64'(m_fpc[15:0]));
        chk("valid", 64'(obs_valid), 64'(e_valid));
        if (e_valid) begin
            chk("pc", obs_pc, {e.pc, 2'b00});
            chk("insn", 64'(obs_insn), 64'(e.insn));
        end

        if (fl) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = tgt;
        end else begin
            if (e_valid && rdy && sz != 0) void'(mq.pop_front());
            if (m_infl && !(byp && rdy)) begin
                if (mq.size() >= FQ_DEPTH) begin
                    errors++;
                    $display("FAIL overflow actual=%0d required<%0d", mq.size(), FQ_DEPTH);
                end
                mq.push_back('{pc: m_pcd1, insn: rd});
            end
            m_infl = e_re;
            if (e_re) begin
                m_pcd1 = m_fpc;
                m_fpc  = m_fpc + 62'd1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pcs[$];
        logic [15:0] adrs[$];
        logic [63:0] r;
        logic [61:0] tgt;

`ifdef IFU_BYPASS_EN
        tbl[0]  = '{1'b1, 1'b1, 16'd0, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 1'b1, 16'd1, 1'b1, 64'h0};
        tbl[2]  = '{1'b1, 1'b1, 16'd2, 1'b1, 64'h4};
        tbl[3]  = '{1'b1, 1'b1, 16'd3, 1'b1, 64'h8};
        tbl[4]  = '{1'b0, 1'b1, 16'd4, 1'b1, 64'hC};
        tbl[5]  = '{1'b0, 1'b1, 16'd5, 1'b1, 64'hC};
        tbl[6]  = '{1'b0, 1'b1, 16'd6, 1'b1, 64'hC};
        tbl[7]  = '{1'b0, 1'b0, 16'd7, 1'b1, 64'hC};
        tbl[8]  = '{1'b1, 1'b0, 16'd7, 1'b1, 64'hC};
        tbl[9]  = '{1'b1, 1'b1, 16'd7, 1'b1, 64'h10};
        tbl[10] = '{1'b1, 1'b1, 16'd8, 1'b1, 64'h14};
        tbl[11] = '{1'b1, 1'b1, 16'd9, 1'b1, 64'h18};
`else
        tbl[0]  = '{1'b1, 1'b1, 16'd0, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 1'b1, 16'd1, 1'b0, 64'h0};
        tbl[2]  = '{1'b1, 1'b1, 16'd2, 1'b1, 64'h0};
        tbl[3]  = '{1'b1, 1'b1, 16'd3, 1'b1, 64'h4};
        tbl[4]  = '{1'b0, 1'b1, 16'd4, 1'b1, 64'h8};
        tbl[5]  = '{1'b0, 1'b1, 16'd5, 1'b1, 64'h8};
        tbl[6]  = '{1'b0, 1'b0, 16'd6, 1'b1, 64'h8};
        tbl[7]  = '{1'b0, 1'b0, 16'd6, 1'b1, 64'h8};
        tbl[8]  = '{1'b1, 1'b0, 16'd6, 1'b1, 64'h8};
        tbl[9]  = '{1'b1, 1'b1, 16'd6, 1'b1, 64'hC};
        tbl[10] = '{1'b1, 1'b1, 16'd7, 1'b1, 64'h10};
        tbl[11] = '{1'b1, 1'b1, 16'd8, 1'b1, 64'h14};
`endif

        bus.i_flush  = 1'b0;
        bus.i_pc_tgt = '0;
        bus.i_ready  = 1'b0;
        rst_n        = 1'b0;
        m_reset();
        #1;
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_re", 64'(bus.o_iram_re), 64'd0);
        chk("rst_insn", 64'(bus.o_insn), 64'd0);
        chk("rst_pc", bus.o_pc, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed table from reset release: streaming, a ready stall, then drain.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, tbl[i].rdy);
            chk($sformatf("tbl%0d_re", i), 64'(obs_re), 64'(tbl[i].re));
            chk($sformatf("tbl%0d_addr", i), 64'(obs_addr), 64'(tbl[i].addr));
            chk($sformatf("tbl%0d_valid", i), 64'(obs_valid), 64'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_pc", i), obs_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_insn", i), 64'(obs_insn), tbl[i].pc >> 2);
            end
        end

        // Flush with three queued entries and a read in flight.
        step(1'b1, 62'h10, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        step(1'b1, 62'h100, 1'b0);
        chk("flush_re", 64'(obs_re), 64'd0);
        step(1'b0, '0, 1'b1);
        chk("postflush_valid", 64'(obs_valid), 64'd0);
        chk("postflush_re", 64'(obs_re), 64'd1);
        chk("postflush_addr", 64'(obs_addr), 64'h100);
        pcs.delete();
        repeat (4) begin
            step(1'b0, '0, 1'b1);
            if (obs_valid) pcs.push_back(obs_pc);
        end
        if (pcs.size() == 0) chk("postflush_first_pc_timeout", 64'd0, 64'd1);
        else                 chk("postflush_first_pc", pcs[0], 64'h400);

        // 62-bit PC wrap.
        step(1'b1, 62'h3FFF_FFFF_FFFF_FFFF, 1'b1);
        pcs.delete();
        adrs.delete();
        repeat (5) begin
            step(1'b0, '0, 1'b1);
            if (obs_re)    adrs.push_back(obs_addr);
            if (obs_valid) pcs.push_back(obs_pc);
        end
        if (adrs.size() < 2) chk("wrap_addr_timeout", 64'd0, 64'd1);
        else begin
            chk("wrap_addr0", 64'(adrs[0]), 64'hFFFF);
            chk("wrap_addr1", 64'(adrs[1]), 64'h0);
        end
        if (pcs.size() < 2) chk("wrap_pc_timeout", 64'd0, 64'd1);
        else begin
            chk("wrap_pc0", pcs[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_pc1", pcs[1], 64'h0);
        end

`ifdef IFU_BYPASS_EN
        // Same-cycle presentation, then a one-cycle stall keeps the word.
        step(1'b1, 62'h20, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("byp_valid", 64'(obs_valid), 64'd1);
        chk("byp_pc", obs_pc, 64'h80);
        step(1'b0, '0, 1'b1);
        chk("byp_stall_valid", 64'(obs_valid), 64'd1);
        chk("byp_stall_pc", obs_pc, 64'h80);
`endif

        // Asynchronous reset with a full queue.
        step(1'b1, 62'h50, 1'b0);
        repeat (6) step(1'b0, '0, 1'b0);
        chk("full_valid", 64'(obs_valid), 64'd1);
        @(negedge clk);
        bus.i_flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.o_valid), 64'd0);
        chk("arst_re", 64'(bus.o_iram_re), 64'd0);
        chk("arst_pc", bus.o_pc, 64'd0);
        chk("arst_insn", 64'(bus.o_insn), 64'd0);
        m_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, '0, 1'b1);
        chk("restart_re", 64'(obs_re), 64'd1);
        chk("restart_addr", 64'(obs_addr), 64'(RST_PC[15:0]));

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r   = {$urandom, $urandom};
            tgt = r[61:0];
            if ($urandom_range(0, 3) == 0) tgt = 62'h3FFF_FFFF_FFFF_FFFC + 62'($urandom_range(0, 3));
            step(($urandom_range(0, 15) == 0), tgt,
                 (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fq.md
Name: ifu_fq

Overview:
- Parametrised successor to the single-register instruction fetch unit.
- Adds a 1-cycle-latency IRAM read path, an in-flight tracker, and an N-entry fetch queue with a valid/ready handshake towards decode.
- Flush (branch/exception redirect) kills in-flight reads and queued instructions, then restarts fetch at the target.
- Sits between the IRAM and decode. Backpressure from decode throttles IRAM reads through a credit rule, so the queue never overflows.

Parameters:
- IRAM_AW, 16, IRAM word-address width.
- FQ_DEPTH, 4, fetch-queue entries; power of two, minimum 2.
- RESET_PC, 62'h0, word address fetched first after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  redirect request; has priority over everything else.
- i_pc_tgt  in  62  redirect target word address.
- o_iram_addr  out  IRAM_AW  IRAM read address, equal to fpc[IRAM_AW-1:0].
- o_iram_re  out  1  IRAM read enable.
- i_iram_rdata  in  32  IRAM read data, valid the cycle after o_iram_re.
- o_valid  out  1  instruction available to decode.
- i_ready  in  1  decode accepts the instruction.
- o_insn  out  32  instruction at the queue head.
- o_pc  out  64  byte PC of o_insn, equal to {pc,2'b00}.

Behaviour:
- Reset (async, rst_n=0):
  - fpc=RESET_PC; queue empty (head=tail=0, count=0); inflight=0.
  - o_valid=0, o_iram_re=0; o_insn and o_pc read 0.
- Fetch issue: o_iram_re = rst_n && !i_flush && (count + inflight < FQ_DEPTH).
  - When o_iram_re=1: fpc <= fpc+1 (62-bit wrap from 2^62-1 to 0), inflight <= 1, pc_d1 <= fpc.
  - Otherwise inflight <= 0.
- Return: when inflight=1 and !i_flush, {pc_d1, i_iram_rdata} is enqueued at tail at the end of that cycle.
- Dequeue: occurs when o_valid && i_ready && !i_flush; head advances.
  - o_insn/o_pc come combinationally from the head entry.
  - o_valid = (count != 0).
- Simultaneous enqueue and dequeue: count unchanged; head and tail both advance and wrap modulo FQ_DEPTH.
- Full: the credit rule guarantees count+inflight <= FQ_DEPTH. An enqueue into a full queue is a design error; the bench asserts it never happens.
- Empty with i_ready=1: no effect.
- Latency, without bypass: re at cycle t, data at t+1, o_valid at t+2. Steady-state throughput is 1 insn/cycle when FQ_DEPTH>=3 and i_ready is held high.
- Flush cycle:
  - o_iram_re=0; queue cleared (count=0, head=tail); inflight data discarded; inflight <= 0.
  - fpc <= i_pc_tgt; no dequeue.
  - First read of the target issues the cycle after the flush.
- Flush while i_ready=0 and queue full: flush still wins; queue empties.
- Back-to-back flushes: only the last target takes effect.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); fetch restarts at RESET_PC after release.

Optional Feature:
- IFU_BYPASS_EN
  - Defined: when count==0, inflight=1 and !i_flush, the returning word drives o_valid=1, o_insn=i_iram_rdata, o_pc={pc_d1,2'b00} in the same cycle. If i_ready=1 the word is consumed and not enqueued; otherwise it is enqueued. Fetch-to-decode latency drops to 1 cycle (o_valid at t+1).
  - Undefined: outputs come only from queue registers, giving a 2-cycle latency and no combinational path from i_iram_rdata to the outputs.

Decomposition:
- Package ifu_pkg:
  - INSN_W=32, PC_W=62.
  - Typedef fq_entry_t {pc[61:0], insn[31:0]}.
  - Default RESET_PC constant.
- Sub-module fetch_queue:
  - Circular buffer of FQ_DEPTH fq_entry_t.
  - Ports: push, push_data, pop, clear, head_data, count.
  - Async active-low reset.
- ifu_fq holds fpc, inflight/pc_d1, the credit rule, bypass muxing and flush control.

Test Plan:
- Reset release, i_ready=1, IRAM returns addr as data: addresses 0,1,2,... issued one per cycle. Without bypass o_valid rises on cycle 2 with o_pc=0x0, o_insn=0, then o_pc=0x4, 0x8, ... every cycle.
- i_ready=0 for 10 cycles, FQ_DEPTH=4: exactly 4 reads issued and o_iram_re falls. On i_ready=1, pc 0x0..0xC drain in order with no loss or duplication.
- Flush with i_pc_tgt=0x100 while queue holds 3 entries and a read is in flight: next cycle o_valid=0. The next read address is 0x100[IRAM_AW-1:0]; the first o_pc after the flush is 0x400, and no stale instruction appears.
- fpc preloaded by flush to 62'h3FFF_FFFF_FFFF_FFFF: following fetches use word addresses ...FFFF then 0; o_pc wraps to 0x0.
- Assert rst_n=0 mid-stream with a full queue: o_valid and o_iram_re drop asynchronously. After release, fetch restarts at RESET_PC.
- With IFU_BYPASS_EN and an empty queue: o_valid is asserted in the same cycle as the IRAM data; a one-cycle i_ready=0 stall pushes the word into the queue and it is presented next cycle.
